pipelined_cla_addsub: RTL and testbench
=======================================

# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from BLOCK-bit lookahead groups, with the carry chain split across STAGES register stages. It is the next-generation ALU adder datapath for the CPU core. It adds a valid/ready handshake with full-throughput stall propagation, a subtract mode, and optional status flags. One operation is accepted per cycle, and results return in order after STAGES cycles.

## Interface
- WIDTH, 32: operand and result width in bits.
- BLOCK, 8: bits per lookahead group. WIDTH % BLOCK == 0; NBLK = WIDTH/BLOCK.
- STAGES, 4: pipeline register stages, range 1..NBLK. NBLK % STAGES == 0; GPS = NBLK/STAGES groups per stage.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  the operand set is valid.
- in_ready  out  1  stage 0 can accept this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- c_in  in  1  carry-in. Ignored when sub=1.
- sub  in  1  1 selects A - B, computed as A + ~B + 1.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- data_result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- c_out  out  1  carry out of bit WIDTH-1. For subtract, 1 means no borrow.
- overflow, zero, negative  out  1 each  status flags. Present only under CLA_FLAGS_EN.

## Operation
- Effective operands:
  - Bi = sub ? ~B : B.
  - ci = sub ? 1 : c_in.
  - Both are captured at acceptance.
- Stage k (0..STAGES-1) handles groups k·GPS .. k·GPS+GPS-1.
  - It takes the carry registered by stage k-1 (ci for stage 0).
  - It computes the group sums, using two-level lookahead across its GPS groups: group G/P, then intra-stage carries.
  - It registers the sum slice, the outgoing carry, the operand bits not yet consumed, the earlier sum slices, and the flag prerequisites.
- Each stage holds a valid bit v[k].
  - Stage k loads when it is empty, or when downstream takes its contents the same cycle.
  - ready[k] = !v[k] | ready[k+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0].
- Transfer:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - out_valid = v[STAGES-1], and the outputs come from the final stage registers.
- Data in a stage that is not advancing holds its value.
- Arithmetic is purely modulo 2^WIDTH. There is no saturation.
- Simultaneous fill and drain on a full pipeline: the transfer completes and throughput stays 1 per cycle.
- in_ready is combinational from out_ready, which is the only combinational input-to-output path.
- Reset while operations are in flight: every v[k] and every data register clears on the next edge, and in-flight operations are discarded.
- The result is a pure function of the captured operands. A stall or a reset-free hold never alters data.

## Timing
- Reset values: out_valid=0, data_result=0, c_out=0, overflow=0, zero=0, negative=0.
  - in_ready equals out_ready | 1 = 1 after reset.
- Latency: an input accepted at edge t appears with out_valid=1 after edge t+STAGES-1, so it is visible in cycle t+STAGES with no stalls.
- Throughput: 1 operation per cycle while out_ready=1.
- Capacity: STAGES operations. With out_ready=0 and a full pipeline, in_ready=0.
- Critical path per stage is about GPS group lookaheads plus one BLOCK-bit CLA.

## Configuration
- CLA_FLAGS_EN defined:
  - overflow = carry into bit WIDTH-1 XOR c_out.
  - zero = (data_result == 0).
  - negative = data_result[WIDTH-1].
  - All three are pipelined alongside the result and reset to 0.
- CLA_FLAGS_EN undefined: the three ports and their registers are absent. Sum, carry and handshake behaviour are identical.

## Structure
- Package cla_pkg holds:
  - function cla_groups(width, block) that returns NBLK;
  - an elaboration-time parameter-legality check (WIDTH % BLOCK, NBLK % STAGES, STAGES ≥ 1);
  - a typedef for per-group G/P pairs.
- Sub-module cla_block: a parametrised BLOCK-bit lookahead group.
  - Inputs: a, b, cin.
  - Outputs: sum, G, P.
  - It is instantiated NBLK times from a generate loop.
- The top module holds the stage registers, the valid/ready chain and the inter-group lookahead.

## Test plan
Configuration for all scenarios: WIDTH=32, BLOCK=8, STAGES=4, CLA_FLAGS_EN defined, unless noted.
- A=0xFFFFFFFF, B=0x00000001, c_in=0, sub=0: after 4 cycles data_result=0x00000000, c_out=1, zero=1, overflow=0.
- A=5, B=7, sub=1: data_result=0xFFFFFFFE, c_out=0, negative=1, overflow=0.
- A=0x7FFFFFFF, B=1: data_result=0x80000000, overflow=1, negative=1, c_out=0.
- Back-to-back streaming with backpressure:
  - Stimulus: 8 back-to-back adds (A=i, B=i, i=1..8) with out_ready held 0 for cycles 2–6.
  - Required: in_ready drops once 4 operations are held, no operation is lost or duplicated, results come out in order 2,4,…,16, and throughput returns to 1 per cycle after release.
- Reset mid-flight: reset_n=0 for one cycle with 3 operations in flight, then out_valid=0 and all outputs 0. The next accepted operation A=1, B=2 returns 3 after 4 cycles.
- Alternate configuration WIDTH=16, BLOCK=4, STAGES=1, CLA_FLAGS_EN undefined:
  - A=0x8000, B=0x8000: data_result=0x0000, c_out=1, 1-cycle latency.
  - Random 10k operations are compared against the A+B+ci reference.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int cla_groups(input int width, input int block);
      return width / block;
   endfunction

   function automatic bit cla_params_ok(input int width, input int block, input int stages);
      if (block < 1 || stages < 1) return 1'b0;
      if (width % block != 0) return 1'b0;
      if (stages > width / block) return 1'b0;
      return ((width / block) % stages) == 0;
   endfunction

endpackage

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead group: slice sum plus group generate/propagate.
module cla_block #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             g,
   output logic             p
);

   logic [BLOCK-1:0] bit_g;
   logic [BLOCK-1:0] bit_p;
   logic [BLOCK-1:0] carry;

   assign bit_g = a & b;
   assign bit_p = a ^ b;

   always_comb begin
      carry[0] = cin;
      for (int i = 1; i < BLOCK; i++) begin
         carry[i] = bit_g[i-1] | (bit_p[i-1] & carry[i-1]);
      end
   end

   assign sum = bit_p ^ carry;

   // Group generate is independent of cin so the stage lookahead can use it early.
   always_comb begin
      g = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
         g = bit_g[i] | (bit_p[i] & g);
      end
   end

   assign p = &bit_p;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor: STAGES register stages of GPS lookahead groups, valid/ready per stage.
// Status flags (overflow, zero, negative) exist only when CLA_FLAGS_EN is defined.
module pipelined_cla_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 8,
   parameter int STAGES = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_result,
   output logic             c_out
`ifdef CLA_FLAGS_EN
   ,
   output logic             overflow,
   output logic             zero,
   output logic             negative
`endif
);

   localparam int NBLK = cla_groups(WIDTH, BLOCK);
   localparam int GPS  = NBLK / STAGES;
   localparam int SW   = GPS * BLOCK;
   localparam int LAST = STAGES - 1;

   if (!cla_params_ok(WIDTH, BLOCK, STAGES)) begin : g_param_check
      $error("pipelined_cla_addsub: illegal WIDTH/BLOCK/STAGES combination");
   end

   logic [WIDTH-1:0]  a_st    [STAGES];
   logic [WIDTH-1:0]  b_st    [STAGES];
   logic [WIDTH-1:0]  s_st    [STAGES];
   logic [WIDTH-1:0]  sum_nxt [STAGES];
   logic [STAGES-1:0] c_st;
   logic [STAGES-1:0] c_nxt;
   logic [STAGES-1:0] up_vld;

   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] v_q;
   logic [STAGES:0]   rdy;

   gp_t  [NBLK-1:0]   gp;
   logic [NBLK-1:0]   grp_cin;
   logic [WIDTH-1:0]  blk_sum;

   // Stage 0 sees the effective operands; later stages see the previous stage registers.
   always_comb begin
      a_st[0]   = A;
      b_st[0]   = sub ? ~B : B;
      c_st[0]   = sub | c_in;
      s_st[0]   = '0;
      up_vld[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_st[k]   = a_q[k-1];
         b_st[k]   = b_q[k-1];
         c_st[k]   = c_q[k-1];
         s_st[k]   = sum_q[k-1];
         up_vld[k] = v_q[k-1];
      end
   end

   always_comb begin
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = ~v_q[k] | rdy[k+1];
      end
   end

   assign in_ready = rdy[0];

   for (genvar j = 0; j < NBLK; j++) begin : g_blk
      localparam int S = j / GPS;
      cla_block #(.BLOCK(BLOCK)) u_blk (
         .a   (a_st[S][j*BLOCK +: BLOCK]),
         .b   (b_st[S][j*BLOCK +: BLOCK]),
         .cin (grp_cin[j]),
         .sum (blk_sum[j*BLOCK +: BLOCK]),
         .g   (gp[j].g),
         .p   (gp[j].p)
      );
   end

   // Second lookahead level: group carries within each stage from group G/P.
   always_comb begin : lookahead
      logic c;
      c       = 1'b0;
      grp_cin = '0;
      c_nxt   = '0;
      for (int k = 0; k < STAGES; k++) begin
         c = c_st[k];
         for (int i = 0; i < GPS; i++) begin
            grp_cin[k*GPS+i] = c;
            c = gp[k*GPS+i].g | (gp[k*GPS+i].p & c);
         end
         c_nxt[k] = c;
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         sum_nxt[k] = s_st[k];
         sum_nxt[k][k*SW +: SW] = blk_sum[k*SW +: SW];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         v_q <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               v_q[k] <= up_vld[k];
               if (up_vld[k]) begin
                  a_q[k]   <= a_st[k];
                  b_q[k]   <= b_st[k];
                  sum_q[k] <= sum_nxt[k];
                  c_q[k]   <= c_nxt[k];
               end
            end
         end
      end
   end

   assign out_valid   = v_q[LAST];
   assign data_result = sum_q[LAST];
   assign c_out       = c_q[LAST];

`ifdef CLA_FLAGS_EN
   logic [STAGES-1:0] z_st;
   logic [STAGES-1:0] z_nxt;
   logic [STAGES-1:0] z_q;
   logic              ov_nxt;
   logic              ov_q;

   always_comb begin
      z_st[0] = 1'b1;
      for (int k = 1; k < STAGES; k++) begin
         z_st[k] = z_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         z_nxt[k] = z_st[k] & (blk_sum[k*SW +: SW] == '0);
      end
      // Same-sign operands yielding an opposite-sign result: equals carry-in(msb) ^ carry-out.
      ov_nxt = (a_st[LAST][WIDTH-1] ~^ b_st[LAST][WIDTH-1]) &
               (sum_nxt[LAST][WIDTH-1] ^ a_st[LAST][WIDTH-1]);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         z_q  <= '0;
         ov_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k] && up_vld[k]) z_q[k] <= z_nxt[k];
         end
         if (rdy[LAST] && up_vld[LAST]) ov_q <= ov_nxt;
      end
   end

   assign overflow = ov_q;
   assign zero     = z_q[LAST];
   assign negative = sum_q[LAST][WIDTH-1];
`endif

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: 32/8/4 instance plus a 16/4/1 instance, checked against an arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_cla_addsub;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset_n;

   logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
   logic [31:0] a, b, data_result;
   logic        in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2, c_out2;
   logic [15:0] a2, b2, data_result2;
`ifdef CLA_FLAGS_EN
   logic overflow, zero, negative;
   logic overflow2, zero2, negative2;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] r;
      logic        c;
      logic        ov;
   } exp_t;

   localparam longint MAXS = 64'sh7FFFFFFF;
   localparam longint MINS = -64'sh80000000;

   pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8), .STAGES(4)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .data_result(data_result), .c_out(c_out)
`ifdef CLA_FLAGS_EN
      , .overflow(overflow), .zero(zero), .negative(negative)
`endif
   );

   pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(1)) dut2 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .A(a2), .B(b2), .c_in(c_in2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
      .data_result(data_result2), .c_out(c_out2)
`ifdef CLA_FLAGS_EN
      , .overflow(overflow2), .zero(zero2), .negative(negative2)
`endif
   );

   // Signed and unsigned interpretation of the operation, straight from its definition.
   function automatic exp_t ref32(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
      exp_t        e;
      longint      sx, sy, full;
      logic [32:0] w;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (s) begin
         e.r  = x - y;
         e.c  = (x >= y);
         full = sx - sy;
      end else begin
         w    = {1'b0, x} + {1'b0, y} + {32'b0, ci};
         e.r  = w[31:0];
         e.c  = w[32];
         full = sx + sy + longint'(ci);
      end
      e.ov = (full > MAXS) || (full < MINS);
      return e;
   endfunction

   function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
      logic [15:0] d;
      if (s) begin
         d = x - y;
         return {(x >= y), d};
      end
      return {1'b0, x} + {1'b0, y} + {16'b0, ci};
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h7FFFFFFF;
         3:       return 32'h80000000;
         default: return $urandom();
      endcase
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({out_valid, c_out, data_result} !== 34'b0)
         $display("FAIL reset_outputs got v=%b c=%b r=%h want all zero", out_valid, c_out, data_result);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if ({out_valid2, c_out2, data_result2} !== 18'b0) begin
         errors++; $display("FAIL reset_outputs2 got v=%b c=%b r=%h want all zero", out_valid2, c_out2, data_result2);
      end
`ifdef CLA_FLAGS_EN
      checks++;
      if ({overflow, zero, negative} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b%b%b want 000", overflow, zero, negative);
      end
`endif
   endtask

   task automatic test_directed();
      logic [31:0] va [5] = '{32'hFFFFFFFF, 32'd5, 32'h7FFFFFFF, 32'h00001234, 32'h80000000};
      logic [31:0] vb [5] = '{32'h00000001, 32'd7, 32'h00000001, 32'h00001234, 32'h00000001};
      logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic        vs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      exp_t e;
      int   lat;
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         a = va[n]; b = vb[n]; c_in = vc[n]; sub = vs[n]; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL dir%0d_in_ready got %b want 1", n, in_ready);
         end
         @(posedge clock);
         @(negedge clock);
         in_valid = 1'b0;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
         end
         checks++;
         if (lat !== 3) begin
            errors++; $display("FAIL dir%0d_latency got %0d cycles want 4", n, lat + 1);
         end
         e = ref32(va[n], vb[n], vc[n], vs[n]);
         checks++;
         if ({data_result, c_out} !== {e.r, e.c}) begin
            errors++; $display("FAIL dir%0d_result got %h c=%b want %h c=%b", n, data_result, c_out, e.r, e.c);
         end
`ifdef CLA_FLAGS_EN
         checks++;
         if ({overflow, zero, negative} !== {e.ov, e.r == 32'h0, e.r[31]}) begin
            errors++; $display("FAIL dir%0d_flags got ov=%b z=%b n=%b want ov=%b z=%b n=%b", n,
                               overflow, zero, negative, e.ov, e.r == 32'h0, e.r[31]);
         end
`endif
         @(posedge clock);
      end
   endtask

   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e;
      int   sent = 0, got = 0, occ = 0, first = -1, last = -1, drops = 0;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         @(negedge clock);
         out_ready = !(cyc >= 2 && cyc <= 6);
         in_valid  = (sent < 8);
         a = sent + 1; b = sent + 1; c_in = 1'b0; sub = 1'b0;
         #1;
         checks++;
         if (in_ready !== ((occ < 4) || out_ready)) begin
            errors++; $display("FAIL b2b_in_ready cyc%0d got %b want %b", cyc, in_ready, (occ < 4) || out_ready);
         end
         if (in_valid && !in_ready) drops++;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_spurious cyc%0d got output %h want none", cyc, data_result);
            end else begin
               e = q.pop_front();
               if (data_result !== e.r) begin
                  errors++; $display("FAIL b2b_order cyc%0d got %h want %h", cyc, data_result, e.r);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
            occ--;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref32(a, b, 1'b0, 1'b0));
            sent++;
            occ++;
         end
         @(posedge clock);
      end
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (got !== 8) begin
         errors++; $display("FAIL b2b_count got %0d results want 8", got);
      end
      checks++;
      if (drops == 0) begin
         errors++; $display("FAIL b2b_stall got %0d refused cycles want >0", drops);
      end
      checks++;
      if (first !== 7 || last !== 14) begin
         errors++; $display("FAIL b2b_throughput got outputs cyc%0d..%0d want 7..14", first, last);
      end
   endtask

   task automatic test_random_stream();
      exp_t q[$];
      exp_t e;
      int   occ = 0;
      for (int cyc = 0; cyc < 460; cyc++) begin
         @(negedge clock);
         in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
         out_ready = (cyc >= 400) || ($urandom_range(0, 2) != 0);
         a = pick32(); b = pick32(); c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (in_ready !== ((occ < 4) || out_ready)) begin
            errors++; $display("FAIL rnd_in_ready cyc%0d got %b want %b", cyc, in_ready, (occ < 4) || out_ready);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rnd_spurious cyc%0d got output %h want none", cyc, data_result);
            end else begin
               e = q.pop_front();
               if ({data_result, c_out} !== {e.r, e.c}) begin
                  errors++; $display("FAIL rnd_result cyc%0d got %h c=%b want %h c=%b", cyc, data_result, c_out, e.r, e.c);
               end
`ifdef CLA_FLAGS_EN
               if ({overflow, zero, negative} !== {e.ov, e.r == 32'h0, e.r[31]}) begin
                  errors++; $display("FAIL rnd_flags cyc%0d got %b%b%b want %b%b%b", cyc,
                                     overflow, zero, negative, e.ov, e.r == 32'h0, e.r[31]);
               end
`endif
            end
            occ--;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref32(a, b, c_in, sub));
            occ++;
         end
         @(posedge clock);
      end
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rnd_drain got %0d pending v=%b want 0 pending v=0", q.size(), out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      int lat;
      @(negedge clock);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'h100 + i; b = 32'h1; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
         @(posedge clock);
         @(negedge clock);
      end
      in_valid = 1'b0;
      reset_n  = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++;
      if ({out_valid, c_out, data_result} !== 34'b0) begin
         errors++; $display("FAIL midrst_outputs got v=%b c=%b r=%h want all zero", out_valid, c_out, data_result);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready);
      end
`ifdef CLA_FLAGS_EN
      checks++;
      if ({overflow, zero, negative} !== 3'b000) begin
         errors++; $display("FAIL midrst_flags got %b%b%b want 000", overflow, zero, negative);
      end
`endif
      out_ready = 1'b1;
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (out_valid !== 1'b0) lat++;
      end
      checks++;
      if (lat != 0) begin
         errors++; $display("FAIL midrst_stale got %0d valid cycles want 0", lat);
      end
      a = 32'd1; b = 32'd2; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checks++;
      if (lat !== 3 || data_result !== 32'd3) begin
         errors++; $display("FAIL midrst_next got %h after %0d cycles want 3 after 4", data_result, lat + 1);
      end
      @(posedge clock);
   endtask

   task automatic test_alt_config();
      logic [16:0] q[$];
      logic [16:0] e;
      int          occ = 0, sent = 0;
      @(negedge clock);
      a2 = 16'h8000; b2 = 16'h8000; c_in2 = 1'b0; sub2 = 1'b0; in_valid2 = 1'b1; out_ready2 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid2 = 1'b0;
      #1;
      checks++;
      if ({out_valid2, c_out2, data_result2} !== {1'b1, 1'b1, 16'h0000}) begin
         errors++; $display("FAIL alt_corner got v=%b c=%b r=%h want v=1 c=1 r=0000", out_valid2, c_out2, data_result2);
      end
      @(posedge clock);
      for (int cyc = 0; cyc < 30000 && (sent < 10000 || q.size() != 0); cyc++) begin
         @(negedge clock);
         in_valid2  = (sent < 10000) && ($urandom_range(0, 7) != 0);
         out_ready2 = ($urandom_range(0, 7) != 0);
         a2 = 16'($urandom()); b2 = 16'($urandom());
         c_in2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (in_ready2 !== ((occ < 1) || out_ready2)) begin
            errors++; $display("FAIL alt_in_ready cyc%0d got %b want %b", cyc, in_ready2, (occ < 1) || out_ready2);
         end
         if (out_valid2 && out_ready2) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL alt_spurious cyc%0d got output %h want none", cyc, data_result2);
            end else begin
               e = q.pop_front();
               if ({c_out2, data_result2} !== e) begin
                  errors++; $display("FAIL alt_result cyc%0d got c=%b r=%h want c=%b r=%h", cyc, c_out2, data_result2, e[16], e[15:0]);
               end
            end
            occ--;
         end
         if (in_valid2 && in_ready2) begin
            q.push_back(ref16(a2, b2, c_in2, sub2));
            sent++;
            occ++;
         end
         @(posedge clock);
      end
      @(negedge clock);
      in_valid2 = 1'b0;
      checks++;
      if (sent != 10000 || q.size() != 0) begin
         errors++; $display("FAIL alt_count got sent=%0d pending=%0d want 10000/0", sent, q.size());
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got no completion want finish before timeout");
      $fatal(1);
   end

   initial begin
      do_reset();
      test_reset();
      test_directed();
      test_back_to_back();
      test_random_stream();
      test_reset_midflight();
      test_alt_config();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
